// File: rtl/inta_sequencer_if.sv
// Signal bundle between the interrupt block / CPU side and the INTA acknowledge sequencer.
// The sequencer connects through the slave modport; whoever drives the request side uses master.
interface inta_sequencer_if;
  logic       int_req;
  logic [2:0] isr_level;
  logic       inta_n;
  logic [4:0] vector_base;
  logic       aeoi_en;
  logic       eoi_cmd;
  logic       int_out;
  logic [1:0] inta_counter;
  logic       aeoi;
  logic       eoi;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output int_req, isr_level, inta_n, vector_base, aeoi_en, eoi_cmd,
    input  int_out, inta_counter, aeoi, eoi, data_out, data_oe
  );

  modport slave (
    input  int_req, isr_level, inta_n, vector_base, aeoi_en, eoi_cmd,
    output int_out, inta_counter, aeoi, eoi, data_out, data_oe
  );
endinterface

// File: rtl/inta_sequencer.sv
// Two-pulse 8086-style INTA controller: raises INT, counts the acknowledge pulses,
// drives the vector byte on the second pulse and forwards EOI controls.
module inta_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  inta_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    ACK2,
    DONE
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_ACK1 = 2'b01;
  localparam logic [1:0] CODE_ACK2 = 2'b10;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   synced;
  logic                   synced_next;
  logic                   fall;
  logic                   rise;
  logic [7:0]             vec_reg;

  assign synced      = sync_q[SYNC_STAGES-1];
  assign synced_next = sync_q[SYNC_STAGES-2];
  assign fall        = dly_q & ~synced;
  assign rise        = ~dly_q & synced;
  assign bus.data_out = vec_reg;

  // Chain resets to all-ones so a released reset never looks like an INTA edge.
  // NOTE: sequential state uses <= so every read in a clocked block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.inta_n};
      dly_q  <= synced;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.eoi <= 1'b0;
    end else begin
      bus.eoi <= bus.eoi_cmd & ~bus.aeoi_en;
    end
  end

  // data_oe looks one stage up the chain so it tracks the synced level with no extra lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.int_out      <= 1'b0;
      bus.inta_counter <= CODE_NONE;
      bus.aeoi         <= 1'b0;
      bus.data_oe      <= 1'b0;
      vec_reg          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.int_req) begin
            state       <= REQ;
            bus.int_out <= 1'b1;
          end
        end
        REQ: begin
          if (fall) begin
            state            <= ACK1;
            bus.int_out      <= 1'b0;
            bus.inta_counter <= CODE_ACK1;
            bus.aeoi         <= bus.aeoi_en;
          end else if (!bus.int_req) begin
            state       <= IDLE;
            bus.int_out <= 1'b0;
          end
        end
        ACK1: begin
          if (fall) begin
            state            <= ACK2;
            bus.inta_counter <= CODE_ACK2;
            vec_reg          <= {bus.vector_base, bus.isr_level};
            bus.data_oe      <= ~synced_next;
          end
        end
        ACK2: begin
          if (rise) begin
            state       <= DONE;
            bus.data_oe <= 1'b0;
          end else begin
            bus.data_oe <= ~synced_next;
          end
        end
        DONE: begin
          state            <= IDLE;
          bus.inta_counter <= CODE_NONE;
          bus.aeoi         <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          bus.int_out      <= 1'b0;
          bus.inta_counter <= CODE_NONE;
          bus.aeoi         <= 1'b0;
          bus.data_oe      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inta_sequencer.md
# inta_sequencer

Acknowledge-cycle controller downstream of the interrupt block (IRR / priority resolver / ISR). It consumes the block's pending-interrupt flag and in-service level and raises the CPU interrupt line. It counts the two 8086-style INTA pulses and drives the `intAcounter` code back into the interrupt block. It places the 8-bit vector `{vector_base, isr_level}` on the data bus during the second pulse and issues the `aeoi`/`eoi` controls that retire the in-service level.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on `inta_n` (legal values 2 or 3).

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `int_req`  in  1  pending-interrupt flag from the interrupt block (`INTtocontrol`).
- `isr_level`  in  3  in-service level from the interrupt block (`ISRtocontrol`).
- `inta_n`  in  1  CPU acknowledge, active low, asynchronous to `clk`.
- `vector_base`  in  5  ICW2 bits T7..T3.
- `aeoi_en`  in  1  auto-EOI mode from ICW4.
- `eoi_cmd`  in  1  one-cycle pulse from the OCW2 non-specific EOI decode.
- `int_out`  out  1  interrupt line to the CPU.
- `inta_counter`  out  2  acknowledge-phase code to the interrupt block (`intAcounter`).
- `aeoi`  out  1  auto-EOI enable to the interrupt block.
- `eoi`  out  1  one-cycle EOI pulse to the interrupt block.
- `data_out`  out  8  vector byte.
- `data_oe`  out  1  bus-drive enable for `data_out`.

## Operation
- `inta_n` passes through a SYNC_STAGES flop chain, followed by one delay flop.
- `fall` = delayed sample high and synced sample low.
- `rise` = delayed sample low and synced sample high.
- FSM states and `inta_counter` code:
  - IDLE: 00.
  - REQ: 00.
  - ACK1: 01.
  - ACK2: 10.
  - DONE: 10.
- IDLE → REQ when `int_req`=1.
- REQ → IDLE when `int_req`=0 and no `fall`.
- REQ → ACK1 on `fall`, regardless of `int_req`. A dropped request is resolved by the interrupt block's spurious (level 7) path.
- ACK1 → ACK2 on the second `fall`. Entering ACK2 latches `vec_reg` = {`vector_base`, `isr_level`}.
- ACK2 → DONE on `rise`.
- DONE → IDLE unconditionally after 1 cycle.
- `int_out` is registered and is 1 only in REQ.
- `fall` in IDLE, or `rise` in REQ/ACK1, is ignored.
- `data_out` = `vec_reg`. `data_oe` = 1 while in ACK2 and the synced `inta_n` is 0.
- `aeoi` is registered from `aeoi_en` on entry to ACK1. It holds that value until the FSM returns to IDLE, so a mode change mid-sequence has no effect.
- `eoi` is a registered copy of (`eoi_cmd` & ~`aeoi_en`). It is independent of the FSM, so an EOI arriving in any state is forwarded.
- Reset values: all outputs 0, state IDLE, `vec_reg` 0, all synchronizer flops 1 (INTA inactive).
- Reset mid-operation aborts the sequence on the reset edge: `data_oe` drops and the counter returns to 00.

## Timing
- With SYNC_STAGES=2, `inta_n` first sampled low at edge k → `fall` valid after edge k+1 → state and `inta_counter` update at edge k+2.
- `rise` follows the same 2-edge latency.
- `int_req` high at edge k → REQ and `int_out`=1 after edge k+1.
- Sequence length seen by the interrupt block:
  - `inta_counter`=01 for the whole gap between the two pulses.
  - `inta_counter`=10 from the second `fall` through one cycle after its `rise`.
- With `int_req` still high, DONE → IDLE → REQ re-asserts `int_out` 2 cycles after DONE. A minimum of 1 low cycle on `int_out` between sequences is guaranteed.
- `isr_level` is sampled on the ACK1→ACK2 edge. The interrupt block must have latched ISR during 01.
- `eoi` has 1-cycle latency from `eoi_cmd`. Back-to-back `eoi_cmd` pulses give back-to-back `eoi` pulses.

## Test plan
- Reset: hold `rst` 3 cycles with `int_req`=1 and `inta_n`=0. Release → all outputs 0 on the first cycle after release, and `int_out`=1 one cycle later once the synchronizer sees `inta_n` high.
- Normal acknowledge:
  - Stimulus: `vector_base`=5'b01000, `isr_level`=3, `int_req`=1, two INTA pulses of 4 cycles low, 4 high.
  - Required: `int_out` high until 2 edges after the first low.
  - Required: `inta_counter` goes 00 → 01 → 10 → 00.
  - Required: `data_out`=8'h43 with `data_oe`=1 only during the second pulse (after sync delay).
- Spurious: drop `int_req` 1 cycle after the first INTA fall → sequence completes with `inta_counter` 01 then 10. `data_out` carries whatever `isr_level` shows (7 from the block).
- Auto-EOI: `aeoi_en`=1 at the first fall, toggled to 0 during ACK1 → `aeoi` stays 1 through DONE and clears in IDLE. `eoi_cmd` pulses with `aeoi_en`=1 produce no `eoi`.
- Manual EOI: `aeoi_en`=0, `eoi_cmd` pulsed during ACK2 and again in IDLE → `eoi` pulses 1 cycle later each time, with the FSM unaffected.
- Reset in ACK2 while `data_oe`=1 → `data_oe`=0, `inta_counter`=00, `int_out`=0 after the reset edge. A new request is then served normally.
